// File: rtl/usr_pkg.sv
// Shared opcode/state types for the universal shift register.
package usr_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD = 3'b000,
        OP_SHL  = 3'b001,
        OP_SHR  = 3'b010,
        OP_LOAD = 3'b011,
        OP_ROTL = 3'b100,
        OP_ROTR = 3'b101,
        OP_ASR  = 3'b110,
        OP_RSVD = 3'b111
    } op_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Ops that move bits one position per step; the rest finish in one cycle.
    function automatic logic is_shift(input op_t op);
        return op inside {OP_SHL, OP_SHR, OP_ROTL, OP_ROTR, OP_ASR};
    endfunction

endpackage

// File: rtl/usr_step.sv
// Single-bit shift/rotate step. Op 110 is arithmetic shift right when
// USR_ASR_EN is defined, otherwise a logical SHR.
module usr_step
    import usr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] q_i,
    input  op_t          op_i,
    input  logic         sin_i,
    output logic [N-1:0] q_o,
    output logic         sout_o
);

    always_comb begin
        q_o    = q_i;
        sout_o = 1'b0;
        case (op_i)
            OP_SHL: begin
                q_o    = {q_i[N-2:0], sin_i};
                sout_o = q_i[N-1];
            end
            OP_SHR: begin
                q_o    = {sin_i, q_i[N-1:1]};
                sout_o = q_i[0];
            end
            OP_ROTL: begin
                q_o    = {q_i[N-2:0], q_i[N-1]};
                sout_o = q_i[N-1];
            end
            OP_ROTR: begin
                q_o    = {q_i[0], q_i[N-1:1]};
                sout_o = q_i[0];
            end
            OP_ASR: begin
`ifdef USR_ASR_EN
                q_o    = {q_i[N-1], q_i[N-1:1]};
`else
                q_o    = {sin_i, q_i[N-1:1]};
`endif
                sout_o = q_i[0];
            end
            default: begin
                q_o    = q_i;
                sout_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// N-bit universal shift register with start/busy/done multi-step shifts.
// Optional arithmetic shift right on op 110 via USR_ASR_EN.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int             N    = 4,
    parameter int             AW   = $clog2(N+1),
    parameter logic [N-1:0]   INIT = N'(4'b0101)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [OP_W-1:0] op_i,
    input  logic [AW-1:0]   amt_i,
    input  logic [N-1:0]    din_i,
    input  logic            sin_i,
    output logic [N-1:0]    q_o,
    output logic            sout_o,
    output logic            busy_o,
    output logic            done_o
);

    state_t         state_q;
    op_t            op_q;
    logic [N-1:0]   q_q;
    logic           sout_q, busy_q, done_q;
    logic [AW-1:0]  cnt_q;

    op_t            op_in;
    op_t            step_op;
    logic [AW-1:0]  amt_sat;
    logic [N-1:0]   step_q;
    logic           step_sout;

    assign op_in   = op_t'(op_i);
    assign amt_sat = (amt_i > AW'(N)) ? AW'(N) : amt_i;
    // In IDLE the first step uses the live opcode; later steps use the latched one.
    assign step_op = (state_q == S_IDLE) ? op_in : op_q;

    usr_step #(.N(N)) u_step (
        .q_i    (q_q),
        .op_i   (step_op),
        .sin_i  (sin_i),
        .q_o    (step_q),
        .sout_o (step_sout)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= OP_HOLD;
            q_q     <= INIT;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (is_shift(op_in) && amt_sat != '0) begin
                            q_q    <= step_q;
                            sout_q <= step_sout;
                            op_q   <= op_in;
                            cnt_q  <= amt_sat - AW'(1);
                            if (amt_sat == AW'(1)) begin
                                done_q <= 1'b1;
                            end else begin
                                busy_q  <= 1'b1;
                                state_q <= S_SHIFT;
                            end
                        end else begin
                            if (op_in == OP_LOAD) q_q <= din_i;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    q_q    <= step_q;
                    sout_q <= step_sout;
                    cnt_q  <= cnt_q - AW'(1);
                    if (cnt_q == AW'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign q_o    = q_q;
    assign sout_o = sout_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
